// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage and its queue.
// Optional build macro used by fetch_unit: FETCH_ALIGN_CHECK_EN.
package fetch_unit_pkg;

    localparam int          FU_AW       = 16;
    localparam int          FU_DW       = 16;
    localparam int          FU_DEPTH    = 2;
    localparam logic [15:0] FU_RESET_PC = 16'h0000;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int fu_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_ins_fifo.sv
// Instruction queue: DEPTH x W circular buffer with occupancy count,
// synchronous clear, and the head entry presented directly from storage.
module fetch_unit_ins_fifo
    import fetch_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic [fu_cnt_w(DEPTH)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = fu_cnt_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    // Full with simultaneous push/pop writes the slot being vacated (wr == rd).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= wdata;
                r_wr        <= r_wr + PW'(1);
            end
            if (pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = r_mem[r_rd];
    assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read per cycle under
// queue credit, drops stale responses after redirect. Macro: FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int             AW       = FU_AW,
    parameter int             DW       = FU_DW,
    parameter int             DEPTH    = FU_DEPTH,
    parameter logic [AW-1:0]  RESET_PC = AW'(FU_RESET_PC)
)(
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_ren,
    output logic [AW-2:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [DW-1:0] ins,
    output logic [AW-1:0] ins_pc,
    output logic          fetch_idle,
    output logic          fault
);

    localparam int CW = fu_cnt_w(DEPTH);

    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    r_req_pc_p1;
    logic             r_inflight_p1;
    logic             r_req_epoch_p1;
    logic             r_epoch;

    logic [CW-1:0]    w_count;
    logic [CW:0]      w_credit;
    logic             w_pop;
    logic             w_push;
    logic             w_stop;
    logic [AW-1:0]    w_redirect_pc;
    logic [DW+AW-1:0] w_head;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    // A misaligned redirect latches fault and stops fetch until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect_valid && redirect_pc[0]) begin
            r_fault <= 1'b1;
        end
    end

    assign w_stop = halt | r_fault;
    assign fault  = r_fault;
`else
    logic w_unused_pc0;

    assign w_unused_pc0 = redirect_pc[0];
    assign w_stop       = halt;
    assign fault        = 1'b0;
`endif

    assign w_redirect_pc = {redirect_pc[AW-1:1], 1'b0};

    assign ins_valid = (w_count != '0);
    assign w_pop     = ins_valid & ins_ready;

    // Slots already promised: queued words plus the in-flight one, less the departing head.
    assign w_credit  = {1'b0, w_count} + (CW+1)'(r_inflight_p1) - (CW+1)'(w_pop);
    assign mem_ren   = rst_n & ~w_stop & ~redirect_valid & (w_credit < (CW+1)'(DEPTH));
    assign mem_raddr = r_pc[AW-1:1];

    assign w_push     = r_inflight_p1 & (r_req_epoch_p1 == r_epoch) & ~redirect_valid;
    assign fetch_idle = w_stop & (w_count == '0) & ~r_inflight_p1;

    // Request stage: PC advance and tag of the word now on the memory port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_epoch        <= 1'b0;
            r_inflight_p1  <= 1'b0;
            r_req_epoch_p1 <= 1'b0;
            r_req_pc_p1    <= '0;
        end else begin
            r_inflight_p1 <= mem_ren;
            if (redirect_valid) begin
                r_pc    <= w_redirect_pc;
                r_epoch <= ~r_epoch;
            end else if (mem_ren) begin
                r_pc <= r_pc + AW'(2);
            end
            if (mem_ren) begin
                r_req_pc_p1    <= r_pc;
                r_req_epoch_p1 <= r_epoch;
            end
        end
    end

    // Response stage: matching-epoch data enters the queue.
    fetch_unit_ins_fifo #(
        .W     (DW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({r_req_pc_p1, mem_rdata}),
        .rdata (w_head),
        .count (w_count)
    );

    assign ins_pc = w_head[DW+AW-1:DW];
    assign ins    = w_head[DW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory word[k] = 16'h1000 + k, expected PCs
// queued on each redirect/reset and consumed on every decode handshake.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_ren;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins;
    logic [15:0] ins_pc;
    logic        fetch_idle;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic [15:0] sb_q[$];

    fetch_unit #(
        .AW       (16),
        .DW       (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .fetch_idle     (fetch_idle),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_rdata = 16'h0000;
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= 16'h1000 + {1'b0, mem_raddr};
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_fill(input logic [15:0] start);
        logic [15:0] pc;
        pc = start;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back(pc);
            pc = pc + 16'd2;
        end
    endtask

    // Handshake monitor: a pop in a redirect cycle is delivered before the flush.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.w_push) begin
                check("push_room", 32'(dut.w_count == 2'(DEPTH) && !dut.w_pop), 32'd0);
            end
            if (ins_valid && ins_ready) begin
                logic [15:0] e;
                n_pop++;
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("ins_pc", 32'(ins_pc), 32'(e));
                    check("ins", 32'(ins), 32'(16'h1000 + {1'b0, e[15:1]}));
                end
            end
            if (redirect_valid) begin
                sb_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (!redirect_pc[0]) sb_fill({redirect_pc[15:1], 1'b0});
`else
                sb_fill({redirect_pc[15:1], 1'b0});
`endif
            end
        end
    end

    task automatic do_redirect(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #1;
        check("redir_ren", 32'(mem_ren), 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("redir_flush", 32'(ins_valid), 32'd0);
    endtask

    task automatic expect_progress(input string tag, input int cycles, input int min_pops);
        int p;
        p = n_pop;
        repeat (cycles) @(posedge clk);
        #1;
        check(tag, 32'(n_pop - p >= min_pops), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] h_ins;
        logic [15:0] h_pc;
        int          p;
        bit          idle_seen;

        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        ins_ready      = 1'b1;
        sb_fill(16'h0000);

        #12;
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_ren", 32'(mem_ren), 32'd0);
        check("rst_ins", 32'(ins), 32'd0);
        check("rst_pc", 32'(ins_pc), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);

        // Release between edges so the next edge is edge 1.
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("valid_e1", 32'(ins_valid), 32'd0);
        @(posedge clk);
        #1;
        check("valid_e2", 32'(ins_valid), 32'd1);
        check("first_ins", 32'(ins), 32'h1000);
        check("first_pc", 32'(ins_pc), 32'h0000);
        p = n_pop;
        repeat (10) @(posedge clk);
        #1;
        check("sustain", 32'(n_pop - p), 32'd10);

        // Back-pressure: head held, issue stops once credit is exhausted.
        ins_ready = 1'b0;
        #1;
        check("stall_ren0", 32'(mem_ren), 32'd0);
        h_ins = ins;
        h_pc  = ins_pc;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(ins_valid), 32'd1);
            check("stall_ins", 32'(ins), 32'(h_ins));
            check("stall_pc", 32'(ins_pc), 32'(h_pc));
            check("stall_ren", 32'(mem_ren), 32'd0);
        end
        ins_ready = 1'b1;
        expect_progress("stall_release", 6, 5);

        // Redirect while streaming: one word in flight, stale response dropped.
        do_redirect(16'h0040);
        expect_progress("redir40_resume", 6, 3);

        // Redirect with a full, stalled queue.
        ins_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_redirect(16'h0080);
        ins_ready = 1'b1;
        expect_progress("redir80_resume", 6, 3);

        // Halt: drain, go idle, then resume sequentially.
        halt = 1'b1;
        #1;
        check("halt_ren", 32'(mem_ren), 32'd0);
        idle_seen = 1'b0;
        for (int c = 0; c < 3 && !idle_seen; c++) begin
            @(posedge clk);
            #1;
            idle_seen = fetch_idle;
        end
        check("halt_idle", 32'(idle_seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("halt_idle_hold", 32'(fetch_idle), 32'd1);
        check("halt_ren_hold", 32'(mem_ren), 32'd0);
        halt = 1'b0;
        #1;
        check("unhalt_idle", 32'(fetch_idle), 32'd0);
        expect_progress("unhalt_resume", 8, 5);

        // PC wrap at the top of the address space.
        do_redirect(16'hFFFE);
        expect_progress("wrap_resume", 8, 5);

        // Misaligned redirect.
        do_redirect(16'h0011);
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_fault", 32'(fault), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("align_ren", 32'(mem_ren), 32'd0);
            check("align_valid", 32'(ins_valid), 32'd0);
        end
        check("align_idle", 32'(fetch_idle), 32'd1);
        check("align_sticky", 32'(fault), 32'd1);
`else
        check("align_nofault", 32'(fault), 32'd0);
        expect_progress("align_resume", 6, 3);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
